// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter bus bundle.
// Carries the per-unit result offers (valid/tag/data with ready back-pressure)
// and the registered CDB broadcast. The execution units and the consumers of the
// broadcast use the master view; the arbiter uses the slave view.
interface cdb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [1:0]             cdb_src;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter for the Tomasulo core.
// Each execution unit (0=ADD, 1=MUL, 2=BCH) parks one tagged result in its own
// hold slot; one slot per cycle wins the CDB and is broadcast from registers.
// Optional feature macro CDB_AGE_PRIO_EN: when defined, the winner is the held
// result closest to rob_head (oldest first, ties to the lower unit index) and the
// round-robin pointer is frozen; when undefined, arbitration is round-robin and
// rob_head is ignored.
module cdb_arbiter #(
    parameter int NREQ   = 3,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             flush,
    input  logic [TAG_W-1:0] rob_head,
    cdb_arbiter_if.slave     bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int POS_W = PTR_W + 1;

    // Hold slots
    logic [NREQ-1:0]   hold_valid_r;
    logic [TAG_W-1:0]  hold_tag_r  [NREQ];
    logic [DATA_W-1:0] hold_data_r [NREQ];

    // Arbitration state and results
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  rr_next_s;
    logic [PTR_W-1:0]  win_s;
    logic              any_s;
    logic [NREQ-1:0]   grant_s;
    logic [NREQ-1:0]   req_ready_s;

    // Registered broadcast
    logic              cdb_valid_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_data_r;
    logic [1:0]        cdb_src_r;

`ifdef CDB_AGE_PRIO_EN
    logic [TAG_W-1:0]  age_s;
    logic [TAG_W-1:0]  best_age_s;
    logic              unused_rr_s;

    assign unused_rr_s = ^{rr_ptr_r, rr_next_s};

    // Oldest-first selection: smallest distance from the ROB head wins, lower index on ties
    always_comb begin
        win_s      = '0;
        any_s      = 1'b0;
        age_s      = '0;
        best_age_s = '1;
        for (int i = 0; i < NREQ; i++) begin
            age_s = hold_tag_r[i] - rob_head;
            if (hold_valid_r[i] && (!any_s || (age_s < best_age_s))) begin
                any_s      = 1'b1;
                best_age_s = age_s;
                win_s      = PTR_W'(i);
            end else begin
                best_age_s = best_age_s;
            end
        end
    end
`else
    logic [POS_W-1:0]  pos_s;
    logic              unused_head_s;

    assign unused_head_s = ^rob_head;

    // Round-robin selection: scan from rr_ptr with wrap, first occupied slot wins
    always_comb begin
        win_s = '0;
        any_s = 1'b0;
        pos_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s = {1'b0, rr_ptr_r} + POS_W'(k);
            if (pos_s >= POS_W'(NREQ)) begin
                pos_s = pos_s - POS_W'(NREQ);
            end else begin
                pos_s = pos_s;
            end
            if (!any_s && hold_valid_r[pos_s[PTR_W-1:0]]) begin
                any_s = 1'b1;
                win_s = pos_s[PTR_W-1:0];
            end else begin
                any_s = any_s;
            end
        end
    end
`endif

    // One-hot grant, ready back-pressure and the next round-robin pointer
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (any_s && (win_s == PTR_W'(i))) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
        // A slot that is being granted may be refilled on the same edge
        if (flush) begin
            req_ready_s = '0;
        end else begin
            req_ready_s = ~hold_valid_r | grant_s;
        end
        if (win_s == PTR_W'(NREQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_s + PTR_W'(1);
        end
    end

    // Hold slot capture on transfer and release on grant; flush drops everything
    always_ff @(posedge clk1) begin
        if (rst) begin
            hold_valid_r <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold_tag_r[i]  <= '0;
                hold_data_r[i] <= '0;
            end
        end else if (flush) begin
            hold_valid_r <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && req_ready_s[i]) begin
                    hold_valid_r[i] <= 1'b1;
                    hold_tag_r[i]   <= bus.req_tag[i*TAG_W +: TAG_W];
                    hold_data_r[i]  <= bus.req_data[i*DATA_W +: DATA_W];
                end else if (grant_s[i]) begin
                    hold_valid_r[i] <= 1'b0;
                end else begin
                    hold_valid_r[i] <= hold_valid_r[i];
                end
            end
        end
    end

    // Broadcast register and round-robin pointer update on each grant
    always_ff @(posedge clk1) begin
        if (rst) begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= '0;
            cdb_data_r  <= '0;
            cdb_src_r   <= 2'd0;
            rr_ptr_r    <= '0;
        end else if (flush) begin
            cdb_valid_r <= 1'b0;
        end else if (any_s) begin
            cdb_valid_r <= 1'b1;
            cdb_tag_r   <= hold_tag_r[win_s];
            cdb_data_r  <= hold_data_r[win_s];
            cdb_src_r   <= 2'(win_s);
`ifdef CDB_AGE_PRIO_EN
            rr_ptr_r    <= rr_ptr_r;
`else
            rr_ptr_r    <= rr_next_s;
`endif
        end else begin
            cdb_valid_r <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.cdb_valid = cdb_valid_r;
    assign bus.cdb_tag   = cdb_tag_r;
    assign bus.cdb_data  = cdb_data_r;
    assign bus.cdb_src   = cdb_src_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for the CDB arbiter.
// The driver keeps a reference model of the pending results per unit; each grant it
// predicts is queued with the edge it should appear after, and a separate monitor
// pops and compares whenever the broadcast is visible.
`timescale 1ns/1ps
module tb_cdb_arbiter;
    localparam int NREQ   = 3;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;

    logic       clk1 = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] rob_head;

    always #5 clk1 = ~clk1;

    cdb_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus();

    cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk1     (clk1),
        .rst      (rst),
        .flush    (flush),
        .rob_head (rob_head),
        .bus      (bus)
    );

    typedef struct {
        logic [2:0]  tag;
        logic [15:0] data;
        logic [1:0]  src;
        int          stamp;
    } bcast_t;

    bcast_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     edge_no = 0;

    // Reference model: one pending result per unit, plus the last broadcast values
    bit          m_valid [3];
    logic [2:0]  m_tag   [3];
    logic [15:0] m_data  [3];
    int          m_rr = 0;
    bit          m_init = 1'b0;
    logic [2:0]  m_last_tag  = 3'd0;
    logic [15:0] m_last_data = 16'd0;
    logic [1:0]  m_last_src  = 2'd0;

    // Which unit the model says should win the bus next; -1 when nothing is pending
    function automatic int pick();
        int best;
        int best_age;
        int age;
        best = -1;
        best_age = 99;
        age = 0;
`ifdef CDB_AGE_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            if (m_valid[i]) begin
                age = (int'(m_tag[i]) - int'(rob_head) + 8) % 8;
                if (age < best_age) begin
                    best_age = age;
                    best = i;
                end
            end
        end
`else
        for (int k = 2; k >= 0; k--) begin
            if (m_valid[(m_rr + k) % 3]) best = (m_rr + k) % 3;
        end
`endif
        return best;
    endfunction

    // Drive one cycle of inputs, check ready, then advance the model across the edge
    task automatic step(input logic [2:0] v, input logic [8:0] tg, input logic [47:0] dt,
                        input logic fl, input logic rs, input logic [2:0] hd);
        int         w;
        logic [2:0] exp_rdy;
        @(negedge clk1);
        #1;
        bus.req_valid = v;
        bus.req_tag   = tg;
        bus.req_data  = dt;
        flush         = fl;
        rst           = rs;
        rob_head      = hd;
        #1;
        w = pick();
        for (int i = 0; i < 3; i++) exp_rdy[i] = !fl && (!m_valid[i] || (w == i));
        if (m_init) begin
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL req_ready: got %b want %b before edge %0d", bus.req_ready, exp_rdy, edge_no + 1);
            end
        end
        @(posedge clk1);
        edge_no++;
        if (rs) begin
            for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
            m_rr = 0;
            m_last_tag = 3'd0;
            m_last_data = 16'd0;
            m_last_src = 2'd0;
            m_init = 1'b1;
        end else if (fl) begin
            for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
        end else begin
            if (w >= 0) begin
                exp_q.push_back('{m_tag[w], m_data[w], 2'(w), edge_no});
                m_last_tag = m_tag[w];
                m_last_data = m_data[w];
                m_last_src = 2'(w);
                m_valid[w] = 1'b0;
`ifndef CDB_AGE_PRIO_EN
                m_rr = (w + 1) % 3;
`endif
            end
            for (int i = 0; i < 3; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_valid[i] = 1'b1;
                    m_tag[i] = tg[i*3 +: 3];
                    m_data[i] = dt[i*16 +: 16];
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic [2:0] hd);
        for (int k = 0; k < n; k++) step(3'b000, 9'd0, 48'd0, 1'b0, 1'b0, hd);
    endtask

    // Scoreboard monitor: compare every visible broadcast with the queued prediction
    initial begin
        bcast_t e;
        forever begin
            @(negedge clk1);
            if (m_init) begin
                checks++;
                if (bus.cdb_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL cdb_spurious: got tag=%0d src=%0d after edge %0d, want no broadcast",
                                 bus.cdb_tag, bus.cdb_src, edge_no);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.cdb_tag !== e.tag || bus.cdb_data !== e.data ||
                            bus.cdb_src !== e.src || e.stamp != edge_no) begin
                            errors++;
                            $display("FAIL cdb_bcast: got tag=%0d data=%h src=%0d edge=%0d want tag=%0d data=%h src=%0d edge=%0d",
                                     bus.cdb_tag, bus.cdb_data, bus.cdb_src, edge_no, e.tag, e.data, e.src, e.stamp);
                        end
                    end
                end else if (bus.cdb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL cdb_valid_x: got %b want 0/1 after edge %0d", bus.cdb_valid, edge_no);
                end else if (exp_q.size() > 0 && exp_q[0].stamp <= edge_no) begin
                    errors++;
                    e = exp_q.pop_front();
                    $display("FAIL cdb_missing: got cdb_valid=0 want tag=%0d src=%0d after edge %0d",
                             e.tag, e.src, e.stamp);
                end else if (bus.cdb_tag !== m_last_tag || bus.cdb_data !== m_last_data ||
                             bus.cdb_src !== m_last_src) begin
                    errors++;
                    $display("FAIL cdb_hold: got tag=%0d data=%h src=%0d want tag=%0d data=%h src=%0d",
                             bus.cdb_tag, bus.cdb_data, bus.cdb_src, m_last_tag, m_last_data, m_last_src);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomised run
    initial begin
        logic [2:0]  rv;
        logic [8:0]  rt;
        logic [47:0] rd;
        bus.req_valid = 3'b000;
        bus.req_tag   = 9'd0;
        bus.req_data  = 48'd0;
        rst           = 1'b1;
        flush         = 1'b0;
        rob_head      = 3'd0;

        // Reset held two cycles, then idle
        step(3'b000, 9'd0, 48'd0, 1'b0, 1'b1, 3'd0);
        step(3'b000, 9'd0, 48'd0, 1'b0, 1'b1, 3'd0);
        idle(3, 3'd0);

        // Single ADD result
        step(3'b001, {3'd0, 3'd0, 3'd2}, {16'h0000, 16'h0000, 16'h0005}, 1'b0, 1'b0, 3'd0);
        idle(3, 3'd0);

        // All three units at once from a freshly reset pointer
        step(3'b000, 9'd0, 48'd0, 1'b0, 1'b1, 3'd0);
        step(3'b111, {3'd6, 3'd4, 3'd1}, {16'h00C6, 16'h00B4, 16'h00A1}, 1'b0, 1'b0, 3'd0);
        idle(4, 3'd0);

        // Saturation: every unit offers a new result each cycle
        for (int k = 0; k < 9; k++) begin
            rt = 9'($urandom);
            rd[31:0] = $urandom;
            rd[47:32] = 16'($urandom);
            step(3'b111, rt, rd, 1'b0, 1'b0, 3'd0);
        end
        idle(4, 3'd0);

        // Flush with all three slots full
        step(3'b111, {3'd7, 3'd3, 3'd0}, {16'h1111, 16'h2222, 16'h3333}, 1'b0, 1'b0, 3'd0);
        step(3'b111, {3'd5, 3'd2, 3'd1}, {16'h4444, 16'h5555, 16'h6666}, 1'b1, 1'b0, 3'd0);
        idle(4, 3'd0);

        // Age ordering scenario: head 5, ADD=3, MUL=6, BCH=5
        step(3'b000, 9'd0, 48'd0, 1'b0, 1'b1, 3'd5);
        step(3'b111, {3'd5, 3'd6, 3'd3}, {16'hB005, 16'hB006, 16'hB003}, 1'b0, 1'b0, 3'd5);
        idle(4, 3'd5);

        // Randomised traffic with occasional flush and reset
        for (int k = 0; k < 400; k++) begin
            rv = 3'($urandom_range(0, 7));
            rt = 9'($urandom);
            rd[31:0] = $urandom;
            rd[47:32] = 16'($urandom);
            step(rv, rt, rd, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0), 3'($urandom));
        end
        idle(5, 3'd0);

        @(negedge clk1);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d predicted broadcasts left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
